// File: rtl/hec_stat_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hec_stat_sched_pkg                                                   |
// | Shared FSM encoding and update-rule constants for hec_stat_sched.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package hec_stat_sched_pkg;

  // Scheduler states: INIT rewrites every band, RUN accepts samples.
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Accumulator step is delta scaled by 4.
  localparam int DELTA_SHIFT = 2;
  // Rounding constant added before the halving rescale.
  localparam int ROUND_ADD   = 1;
  // Extra intermediate bits above the accumulator width.
  localparam int GUARD_BITS  = 1;
  // Counter multiplier presented to the comparator stage.
  localparam int CNT49_MULT  = 49;

endpackage
`default_nettype wire

// File: rtl/hec_stat_update.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hec_stat_update                                                      |
// | Per-band statistics update: accumulate 4*delta and bump the counter, |
// | or halve both when the counter reaches its rescale point.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hec_stat_update
  import hec_stat_sched_pkg::*;
#(
  parameter int ACC_WIDTH  = 29,
  parameter int D_WIDTH    = 16,
  parameter int P_WIDTH    = 8,
  parameter int GAMMA_STAR = 6
) (
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic [P_WIDTH-1:0]   cnt,
  input  logic [D_WIDTH-1:0]   delta,
  output logic [ACC_WIDTH-1:0] acc_new,
  output logic [P_WIDTH-1:0]   cnt_new
);

  localparam int IW = ACC_WIDTH + GUARD_BITS;
  localparam logic [P_WIDTH-1:0] CNT_MAX  = P_WIDTH'((1 << GAMMA_STAR) - 1);
  localparam logic [P_WIDTH-1:0] CNT_HALF = P_WIDTH'(1 << (GAMMA_STAR - 1));

  logic [IW-1:0] w_sum;
  logic [IW-1:0] w_rnd;

  // Unsigned wrap-around arithmetic; the guard bit keeps the carry for the halving path.
  always_comb begin
    w_sum = {{GUARD_BITS{1'b0}}, acc} + (IW'(delta) << DELTA_SHIFT);
    w_rnd = w_sum + IW'(ROUND_ADD);
    if (cnt == CNT_MAX) begin
      acc_new = ACC_WIDTH'(w_rnd >> 1);
      cnt_new = CNT_HALF;
    end else begin
      acc_new = w_sum[ACC_WIDTH-1:0];
      cnt_new = cnt + P_WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/hec_stat_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hec_stat_sched                                                       |
// | Holds per-band accumulator/counter statistics, issues the pre-update |
// | state of each accepted sample one cycle later, and writes the        |
// | updated state back in the issue cycle with same-band forwarding.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hec_stat_sched
  import hec_stat_sched_pkg::*;
#(
  parameter int NBANDS      = 8,
  parameter int BAND_W      = 3,
  parameter int D_WIDTH     = 16,
  parameter int ACC_WIDTH   = 29,
  parameter int CNT49_WIDTH = 14,
  parameter int P_WIDTH     = 8,
  parameter int GAMMA0      = 1,
  parameter int GAMMA_STAR  = 6,
  parameter int ACC_INIT    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   init_i,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BAND_W-1:0]      in_band,
  input  logic [D_WIDTH-1:0]     in_delta,
  output logic                   cpr_en_o,
  output logic [P_WIDTH-1:0]     pcnt_o,
  output logic [CNT49_WIDTH-1:0] cnt49_o,
  output logic [ACC_WIDTH-1:0]   acc_o,
  output logic                   busy_o
);

  localparam int IDX_W = (NBANDS > 1) ? $clog2(NBANDS) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NBANDS - 1);
  localparam logic [P_WIDTH-1:0]   CNT_INIT = P_WIDTH'(1 << GAMMA0);
  localparam logic [ACC_WIDTH-1:0] ACC_RST  = ACC_WIDTH'(ACC_INIT);

  state_t                 r_state;
  logic [IDX_W-1:0]       r_init_idx;

  logic [ACC_WIDTH-1:0]   r_acc_mem [0:NBANDS-1];
  logic [P_WIDTH-1:0]     r_cnt_mem [0:NBANDS-1];

  // Issue stage: band/delta of the sample being issued plus its pre-update state.
  logic                   r_iss_vld;
  logic [IDX_W-1:0]       r_iss_band;
  logic [D_WIDTH-1:0]     r_iss_delta;
  logic [P_WIDTH-1:0]     r_pcnt;
  logic [CNT49_WIDTH-1:0] r_cnt49;
  logic [ACC_WIDTH-1:0]   r_acc;

  logic                   w_accept;
  logic                   w_band_ok;
  logic [IDX_W-1:0]       w_rd_idx;
  logic                   w_fwd;
  logic [ACC_WIDTH-1:0]   w_rd_acc;
  logic [P_WIDTH-1:0]     w_rd_cnt;
  logic [CNT49_WIDTH-1:0] w_cnt49;
  logic [ACC_WIDTH-1:0]   w_upd_acc;
  logic [P_WIDTH-1:0]     w_upd_cnt;

  // The update is computed from the issued state, so it is ready in the issue cycle.
  hec_stat_update #(
    .ACC_WIDTH (ACC_WIDTH),
    .D_WIDTH   (D_WIDTH),
    .P_WIDTH   (P_WIDTH),
    .GAMMA_STAR(GAMMA_STAR)
  ) u_update (
    .acc    (r_acc),
    .cnt    (r_pcnt),
    .delta  (r_iss_delta),
    .acc_new(w_upd_acc),
    .cnt_new(w_upd_cnt)
  );

  // Handshake and band read; a same-band sample right behind an issue sees the fresh update.
  always_comb begin
    in_ready  = (r_state == ST_RUN) && !init_i;
    w_accept  = in_valid && in_ready;
    w_band_ok = 32'(in_band) < 32'(NBANDS);
    w_rd_idx  = w_band_ok ? in_band[IDX_W-1:0] : '0;
    w_fwd     = r_iss_vld && (r_iss_band == w_rd_idx);
    w_rd_acc  = w_fwd ? w_upd_acc : r_acc_mem[w_rd_idx];
    w_rd_cnt  = w_fwd ? w_upd_cnt : r_cnt_mem[w_rd_idx];
    w_cnt49   = CNT49_WIDTH'(w_rd_cnt) * CNT49_WIDTH'(CNT49_MULT);
  end

  assign busy_o   = (r_state == ST_INIT);
  assign cpr_en_o = r_iss_vld;
  assign pcnt_o   = r_pcnt;
  assign cnt49_o  = r_cnt49;
  assign acc_o    = r_acc;

  // Control FSM and registered issue outputs; reset drops any in-flight issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_init_idx  <= '0;
      r_iss_vld   <= 1'b0;
      r_iss_band  <= '0;
      r_iss_delta <= '0;
      r_pcnt      <= '0;
      r_cnt49     <= '0;
      r_acc       <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (init_i) begin
            r_init_idx <= '0;
          end else if (r_init_idx == LAST_IDX) begin
            r_init_idx <= '0;
            r_state    <= ST_RUN;
          end else begin
            r_init_idx <= r_init_idx + IDX_W'(1);
          end
        end
        ST_RUN: begin
          if (init_i) begin
            r_init_idx <= '0;
            r_state    <= ST_INIT;
          end
        end
        default: begin
          r_init_idx <= '0;
          r_state    <= ST_INIT;
        end
      endcase

      r_iss_vld   <= w_accept && w_band_ok;
      r_iss_band  <= w_rd_idx;
      r_iss_delta <= in_delta;
      if (w_accept && w_band_ok) begin
        r_pcnt  <= w_rd_cnt;
        r_cnt49 <= w_cnt49;
        r_acc   <= w_rd_acc;
      end else begin
        r_pcnt  <= '0;
        r_cnt49 <= '0;
        r_acc   <= '0;
      end
    end
  end

  // Band storage: INIT sweeps one band per cycle, RUN writes back the issued band.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_acc_mem[r_init_idx] <= ACC_RST;
      r_cnt_mem[r_init_idx] <= CNT_INIT;
    end else if (r_iss_vld) begin
      r_acc_mem[r_iss_band] <= w_upd_acc;
      r_cnt_mem[r_iss_band] <= w_upd_cnt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hec_stat_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hec_stat_sched                                                    |
// | Scoreboard bench: a per-band reference model predicts each issue;    |
// | a monitor compares DUT issues against the queued predictions.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_hec_stat_sched;

  localparam int NB  = 8;
  localparam int BW  = 4;   // wider than needed so out-of-range bands can be driven
  localparam int DW  = 16;
  localparam int AW  = 29;
  localparam int CW  = 14;
  localparam int PW  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_i;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_band;
  logic [DW-1:0] in_delta;
  logic          cpr_en_o;
  logic [PW-1:0] pcnt_o;
  logic [CW-1:0] cnt49_o;
  logic [AW-1:0] acc_o;
  logic          busy_o;

  always #5 clk = ~clk;

  hec_stat_sched #(
    .NBANDS(NB), .BAND_W(BW), .D_WIDTH(DW), .ACC_WIDTH(AW),
    .CNT49_WIDTH(CW), .P_WIDTH(PW), .GAMMA0(1), .GAMMA_STAR(6), .ACC_INIT(0)
  ) dut (
    .clk(clk), .rst(rst), .init_i(init_i), .in_valid(in_valid),
    .in_ready(in_ready), .in_band(in_band), .in_delta(in_delta),
    .cpr_en_o(cpr_en_o), .pcnt_o(pcnt_o), .cnt49_o(cnt49_o),
    .acc_o(acc_o), .busy_o(busy_o)
  );

  typedef struct {
    longint pcnt;
    longint cnt49;
    longint acc;
    int     due;
  } exp_t;

  exp_t   sb[$];
  longint m_acc [NB];
  longint m_cnt [NB];
  int     m_init_left;
  int     cyc = 0;
  int     checks = 0;
  int     failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every band restarts at acc=ACC_INIT, cnt=2**GAMMA0.
  task automatic model_init();
    for (int i = 0; i < NB; i++) begin
      m_acc[i] = 0;
      m_cnt[i] = 2;
    end
  endtask

  // Predict the issue (pre-update state) and apply the update rule to the band.
  task automatic model_accept(input int b, input longint d);
    exp_t   e;
    longint s;
    e.pcnt  = m_cnt[b];
    e.cnt49 = (m_cnt[b] * 49) % (longint'(1) << CW);
    e.acc   = m_acc[b];
    e.due   = cyc + 1;
    sb.push_back(e);
    s = (m_acc[b] + 4 * d) % (longint'(1) << (AW + 1));
    if (m_cnt[b] == 63) begin
      m_acc[b] = (((s + 1) % (longint'(1) << (AW + 1))) / 2) % (longint'(1) << AW);
      m_cnt[b] = 32;
    end else begin
      m_acc[b] = s % (longint'(1) << AW);
      m_cnt[b] = m_cnt[b] + 1;
    end
  endtask

  // One cycle of stimulus, called right after a falling edge; returns at the next one.
  task automatic cycle(input bit v, input int b, input int d, input bit ini);
    bit exp_ready;
    in_valid = v;
    in_band  = b[BW-1:0];
    in_delta = d[DW-1:0];
    init_i   = ini;
    #1;
    exp_ready = (m_init_left == 0) && !ini;
    check("in_ready", longint'(in_ready), longint'(exp_ready));
    check("busy_o", longint'(busy_o), longint'(m_init_left > 0));
    if (v && exp_ready && b < NB) model_accept(b, longint'(d));
    if (ini) begin
      m_init_left = NB;
      model_init();
    end else if (m_init_left > 0) begin
      m_init_left--;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b0);
  endtask

  // Assert reset between edges (optionally with a sample being offered) and release on a falling edge.
  task automatic do_reset(input bit with_traffic);
    in_valid = with_traffic;
    in_band  = 4'd5;
    in_delta = 16'd7;
    init_i   = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rst_cpr_en", longint'(cpr_en_o), 0);
    check("rst_pcnt", longint'(pcnt_o), 0);
    check("rst_cnt49", longint'(cnt49_o), 0);
    check("rst_acc", longint'(acc_o), 0);
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_busy", longint'(busy_o), 1);
    sb.delete();
    model_init();
    m_init_left = NB;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every issue must match the oldest prediction due this cycle.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_issue actual=none expected_due_cycle=%0d now=%0d", sb[0].due, cyc);
        void'(sb.pop_front());
      end
      if (cpr_en_o) begin
        if (sb.size() == 0 || sb[0].due != cyc) begin
          checks++;
          failures++;
          $display("FAIL unexpected_issue actual cpr_en_o=1 expected=0 cycle=%0d", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("issue_pcnt", longint'(pcnt_o), e.pcnt);
          check("issue_cnt49", longint'(cnt49_o), e.cnt49);
          check("issue_acc", longint'(acc_o), e.acc);
        end
      end else begin
        check("idle_pcnt", longint'(pcnt_o), 0);
        check("idle_cnt49", longint'(cnt49_o), 0);
        check("idle_acc", longint'(acc_o), 0);
      end
    end
  end

  initial begin
    rst      = 1'b1;
    init_i   = 1'b0;
    in_valid = 1'b0;
    in_band  = '0;
    in_delta = '0;
    model_init();
    m_init_left = NB;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Power-up INIT sweep, then first band 3 issue (cnt 2, 49*2, acc 0).
    idle(NB);
    cycle(1'b1, 3, 0, 1'b0);
    idle(1);

    // Same band back to back: second issue must see the forwarded update.
    cycle(1'b1, 2, 5, 1'b0);
    cycle(1'b1, 2, 5, 1'b0);
    idle(1);

    // Drive band 1 to cnt=63/acc=100, then the rescale and the issue after it.
    for (int i = 0; i < 61; i++) cycle(1'b1, 1, (i < 25) ? 1 : 0, 1'b0);
    cycle(1'b1, 1, 10, 1'b0);
    cycle(1'b1, 1, 0, 1'b0);
    idle(1);

    // Re-init while band 4 is in flight; band 4 reads fresh state afterwards.
    cycle(1'b1, 4, 9, 1'b0);
    cycle(1'b0, 0, 0, 1'b1);
    idle(NB);
    cycle(1'b1, 4, 0, 1'b0);

    // Interleaved bands 0 and 1.
    cycle(1'b1, 0, 1, 1'b0);
    cycle(1'b1, 1, 1, 1'b0);
    cycle(1'b1, 0, 1, 1'b0);
    cycle(1'b1, 1, 1, 1'b0);
    idle(1);

    // Out-of-range bands are accepted but never issued and change nothing.
    cycle(1'b1, 9, 100, 1'b0);
    cycle(1'b1, 15, 3, 1'b0);
    cycle(1'b1, 2, 1, 1'b0);
    idle(1);

    // Re-init during INIT restarts the sweep; samples offered while not ready are ignored.
    cycle(1'b0, 0, 0, 1'b1);
    cycle(1'b1, 2, 5, 1'b0);
    idle(2);
    cycle(1'b0, 0, 0, 1'b1);
    cycle(1'b1, 3, 7, 1'b0);
    idle(NB - 1);
    cycle(1'b1, 2, 0, 1'b0);
    idle(1);

    // Randomised traffic with occasional re-init and out-of-range bands.
    for (int n = 0; n < 3000; n++) begin
      bit v;
      bit ini;
      int b;
      int d;
      v   = ($urandom_range(0, 3) != 0);
      b   = int'($urandom_range(0, 9));
      d   = int'($urandom_range(0, 65535));
      ini = ($urandom_range(0, 199) == 0);
      cycle(v, b, d, ini);
    end
    idle(NB + 2);

    // Reset while an issue is showing and another sample is offered.
    cycle(1'b1, 6, 2, 1'b0);
    check("pre_rst_issue", longint'(cpr_en_o), 1);
    do_reset(1'b1);
    idle(NB);
    cycle(1'b1, 6, 0, 1'b0);
    cycle(1'b1, 5, 0, 1'b0);
    idle(2);

    check("sb_drained", longint'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
